// File: rtl/jtframe_romrq_slot.sv
// jtframe_romrq_slot
// ROM-slot responder placed between a ROM requester (CPU or video side) and
// the SDRAM arbiter. It keeps a two-entry cache of 16-bit words. On a miss,
// it issues one read request and fills a cache entry. data_ok is registered
// from the live address every clock. As a result, it drops no later than one
// clock after the address changes.
//
// Ports
//   rst        synchronous active-high reset
//   clk        system clock
//   clr        invalidate both cache entries (ROM download/reload)
//   addr       requester address (byte address if DW=8, word address if DW=16)
//   addr_ok    requester chip select
//   sdram_addr word address presented to the arbiter
//   req        read request to the arbiter, held until req_ok
//   req_ok     arbiter accepted the request (1-cycle pulse)
//   din        SDRAM read word
//   din_ok     din valid for this slot (1-cycle pulse)
//   dout       data returned to the requester
//   data_ok    dout is valid for the current addr
module jtframe_romrq_slot #(
   parameter int AW = 18,
   parameter int DW = 8      // 8 or 16 only
) (
   input  logic          rst,
   input  logic          clk,
   input  logic          clr,
   input  logic [AW-1:0] addr,
   input  logic          addr_ok,
   output logic [AW-1:0] sdram_addr,
   output logic          req,
   input  logic          req_ok,
   input  logic [15:0]   din,
   input  logic          din_ok,
   output logic [DW-1:0] dout,
   output logic          data_ok
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, FLUSH} state_t;

   state_t          state_q, state_d;
   logic            req_q, req_d;
   logic [AW-1:0]   sdram_addr_q, sdram_addr_d;
   logic [1:0]      valid_q, valid_d;
   logic            victim_q, victim_d;
   logic            fill_we;
   logic            data_ok_q;
   logic [DW-1:0]   dout_q, dout_d;

   logic [AW-1:0]   tag_q  [2];
   logic [15:0]     word_q [2];

   logic [AW-1:0]   wa;
   logic [1:0]      match;
   logic            hit;
   logic [15:0]     sel_word;

   // Word address and byte lane selection depend on the output width.
   generate
      if (DW == 8) begin : g_byte
         assign wa     = {1'b0, addr[AW-1:1]};
         assign dout_d = addr[0] ? sel_word[15:8] : sel_word[7:0];
      end else begin : g_word
         assign wa     = addr;
         assign dout_d = sel_word;
      end
   endgenerate

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_match
         assign match[gi] = valid_q[gi] & (tag_q[gi] == wa);
      end
   endgenerate

   // Fills always go to the victim entry, which never holds the tag being fetched.
   // Two entries therefore never match at the same time. XOR also keeps a
   // corrupted double match from being reported as a hit.
   assign hit      = addr_ok & (match[0] ^ match[1]);
   assign sel_word = match[0] ? word_q[0] : word_q[1];

   always_comb begin
      state_d      = state_q;
      req_d        = req_q;
      sdram_addr_d = sdram_addr_q;
      valid_d      = valid_q;
      victim_d     = victim_q;
      fill_we      = 1'b0;
      if (clr) valid_d = 2'b00;
      case (state_q)
         IDLE: begin
            if (addr_ok && !hit && !clr) begin
               sdram_addr_d = wa;
               req_d        = 1'b1;
               state_d      = REQ;
            end
         end
         REQ: begin
            if (clr) begin
               req_d   = 1'b0;
               state_d = IDLE;
            end else if (req_ok) begin
               req_d   = 1'b0;
               state_d = WAIT;
            end
         end
         WAIT: begin
            // After clr, the arbiter still delivers the accepted transfer.
            // FLUSH absorbs it unless it arrives in this same cycle.
            if (clr) begin
               state_d = din_ok ? IDLE : FLUSH;
            end else if (din_ok) begin
               fill_we           = 1'b1;
               valid_d[victim_q] = 1'b1;
               victim_d          = ~victim_q;
               state_d           = IDLE;
            end
         end
         FLUSH: begin
            if (din_ok) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         req_q        <= 1'b0;
         sdram_addr_q <= '0;
         valid_q      <= 2'b00;
         victim_q     <= 1'b0;
         data_ok_q    <= 1'b0;
         dout_q       <= '0;
      end else begin
         state_q      <= state_d;
         req_q        <= req_d;
         sdram_addr_q <= sdram_addr_d;
         valid_q      <= valid_d;
         victim_q     <= victim_d;
         data_ok_q    <= hit & ~clr;
         dout_q       <= dout_d;
      end
   end

   // The tag comes from the latched request address. The live address may
   // already have moved on by the time the data arrives.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            tag_q[i]  <= '0;
            word_q[i] <= '0;
         end
      end else if (fill_we) begin
         tag_q[victim_q]  <= sdram_addr_q;
         word_q[victim_q] <= din;
      end
   end

   assign sdram_addr = sdram_addr_q;
   assign req        = req_q;
   assign dout       = dout_q;
   assign data_ok    = data_ok_q;

endmodule
